mult_control_unit: RTL
======================

MULT_CONTROL_UNIT -- requirements
Module: mult_control_unit

Interface
REQ-001 WIDTH, 8, operand width; the block SHALL run WIDTH add/shift iterations per multiply.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-low; takes effect only on a rising Clk edge.
REQ-004 Run  input  1  start request, level-sensitive, synchronised upstream.
REQ-005 ClearA_LoadB  input  1  request to clear the A register and the X flip-flop, and load B from switches.
REQ-006 M  input  1  current LSB of the B register.
REQ-007 Clr_Ld  output  1  clear A and X, load B (datapath, one cycle).
REQ-008 ClrA_X  output  1  clear A and the X flip-flop at multiply start.
REQ-009 Add  output  1  A <= A + S (sign-extended), one cycle.
REQ-010 Sub  output  1  A <= A - S (sign-extended), one cycle.
REQ-011 Ld_X  output  1  load enable to the X sign flip-flop.
REQ-012 Shift  output  1  arithmetic right shift of X:A:B by one.
REQ-013 Busy  output  1  high in every state except IDLE and HOLD.
REQ-014 Done  output  1  high in HOLD only.

Function
REQ-015 States SHALL be IDLE, START, ADD, SHIFT, HOLD, with an iteration counter of clog2(WIDTH) bits.
REQ-016 IDLE: Run=1 -> START next cycle, and Clr_Ld SHALL stay 0 even if ClearA_LoadB=1 (Run has priority).
REQ-017 IDLE: Run=0 and ClearA_LoadB=1 -> Clr_Ld=1 in that same cycle (combinational), and the state SHALL stay IDLE.
REQ-018 ClearA_LoadB SHALL be ignored outside IDLE.
REQ-019 START: ClrA_X=1 for exactly one cycle; counter <= 0; next state ADD.
REQ-020 ADD with M=1 and counter<WIDTH-1: Add=1 and Ld_X=1 in that cycle.
REQ-021 ADD with M=1 and counter=WIDTH-1: Sub=1 and Ld_X=1 in that cycle, and Add SHALL be 0.
REQ-022 ADD with M=0: Add=Sub=Ld_X=0.
REQ-023 ADD SHALL always go to SHIFT next cycle.
REQ-024 SHIFT: Shift=1 for one cycle.
REQ-025 SHIFT with counter=WIDTH-1: next state HOLD, counter wraps to 0.
REQ-026 SHIFT with counter<WIDTH-1: counter increments by 1 and the next state is ADD.
REQ-027 HOLD: Done=1; the block SHALL stay in HOLD while Run=1 and return to IDLE on the first cycle Run=0. A held Run SHALL never retrigger a multiply.
REQ-028 Add, Sub and Ld_X SHALL depend only on the state, the counter and M. All other outputs SHALL be pure functions of the state.
REQ-029 Add, Sub, Shift, ClrA_X and Clr_Ld SHALL be mutually exclusive in every cycle.
REQ-030 Latency: with Run sampled high in IDLE at edge 0, START occupies cycle 1; ADDk occupies cycle 2+2k and SHIFTk occupies cycle 3+2k; Done first rises in cycle 2*WIDTH+2 (cycle 18 for WIDTH=8).
REQ-031 Exactly WIDTH Shift pulses SHALL occur per multiply.

Reset
REQ-032 Reset=0 at a rising edge SHALL force IDLE and counter=0, including mid-multiply, overriding all other inputs.
REQ-033 From the cycle after reset, all outputs SHALL read 0, except Clr_Ld, which follows REQ-017.
REQ-034 While Reset=0, no state change other than the forced IDLE SHALL occur.
REQ-035 Releasing Reset with Run=1 SHALL start a multiply on the first edge after release.

Verification
REQ-036 WIDTH=8, M sequence from B=8'h05, Run pulsed at edge 0 -> Add in cycles 2 and 6 only, Sub never, 8 Shift pulses in cycles 3,5,...,17, Done=1 at cycle 18.
REQ-037 B=8'h80 (M=1 only at iteration 7) -> Sub=1 and Ld_X=1 in cycle 16, Add never asserted.
REQ-038 B=8'hFF -> Add in iterations 0-6, Sub in iteration 7, Ld_X high in all 8 ADD cycles.
REQ-039 Run held high for 40 cycles -> a single multiply, Done high from cycle 18 until Run drops, IDLE the next cycle.
REQ-040 Reset=0 during SHIFT3 -> IDLE next cycle, all outputs 0, the next Run gives a full 8-iteration sequence.
REQ-041 IDLE with Run=ClearA_LoadB=1 -> Clr_Ld=0, START next cycle.
REQ-042 IDLE with ClearA_LoadB=1 for 3 cycles and Run=0 -> Clr_Ld=1 for those 3 cycles, state stays IDLE.

Source files
------------

// File: rtl/mult_control_unit.sv
// Sequencer for a WIDTH-bit add/shift signed multiplier.
// Drives the A/X/B datapath: clears and loads, WIDTH add-or-subtract/shift
// iterations, then holds Done until Run is released.
module mult_control_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClrA_X,
    output logic Add,
    output logic Sub,
    output logic Ld_X,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    // Counter is clog2(WIDTH) bits; keep at least one bit for degenerate widths.
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAdd,
        StShift,
        StHold
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // State and iteration counter; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and datapath controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        Clr_Ld  = 1'b0;
        ClrA_X  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Ld_X    = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Run wins over a simultaneous clear/load request.
                if (Run) begin
                    state_d = StStart;
                end else if (ClearA_LoadB) begin
                    Clr_Ld = 1'b1;
                end
            end
            StStart: begin
                ClrA_X  = 1'b1;
                Busy    = 1'b1;
                cnt_d   = '0;
                state_d = StAdd;
            end
            StAdd: begin
                Busy = 1'b1;
                // The final partial product carries the sign bit of B, so it is subtracted.
                if (M) begin
                    Ld_X = 1'b1;
                    if (cnt_q == CntLast) begin
                        Sub = 1'b1;
                    end else begin
                        Add = 1'b1;
                    end
                end
                state_d = StShift;
            end
            StShift: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StAdd;
                end
            end
            StHold: begin
                // Wait for Run to drop so a held Run cannot retrigger.
                Done = 1'b1;
                if (!Run) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
